// File: rtl/spawn_piece_placer.sv
// spawn_piece_placer
//
// Collects the four spawn cells of a new piece from the piece generator and
// checks each one against the board (bounds and occupancy). A clean spawn is
// written into the board and handed to the falling-piece controller. A blocked
// spawn raises the sticky game_over flag. If the generator never signals done,
// the request is aborted with place_err.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   start               single-cycle spawn request (only accepted when idle)
//   gen_*               piece generator handshake and streamed cells
//   board_rd_*          board read port (data returns one cycle later)
//   board_we/board_wr_* board write port
//   cell_i, cell_j      committed cells, cell k at bits [5k+4:5k]
//   active_type         committed piece type
//   busy                high in every state except IDLE
//   place_done          one-cycle pulse at the end of every request
//   place_err           qualifies place_done: 1 = generator timeout abort
//   game_over           sticky spawn-collision flag
//
// Build option:
//   SPAWN_OVERWRITE_EN  when defined, a colliding piece is still written
//                       (in-bounds cells only) before game_over is raised.
//
// Piece encoding: NULL_PIECE marks an empty board cell.

`ifndef NULL_PIECE
`define NULL_PIECE 3'd7
`endif

module spawn_piece_placer #(
    parameter int ROWS            = 20,
    parameter int COLS            = 10,
    parameter int COLLECT_TIMEOUT = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        gen_enable,
    output logic        gen_real_generate,
    input  logic [4:0]  gen_pos_i,
    input  logic [4:0]  gen_pos_j,
    input  logic [2:0]  gen_piece_type,
    input  logic        gen_done,
    output logic [4:0]  board_rd_i,
    output logic [4:0]  board_rd_j,
    input  logic [2:0]  board_rd_data,
    output logic        board_we,
    output logic [4:0]  board_wr_i,
    output logic [4:0]  board_wr_j,
    output logic [2:0]  board_wr_data,
    output logic [19:0] cell_i,
    output logic [19:0] cell_j,
    output logic [2:0]  active_type,
    output logic        busy,
    output logic        place_done,
    output logic        place_err,
    output logic        game_over
);

    localparam logic [4:0]    ROW_LIM  = 5'(ROWS);
    localparam logic [4:0]    COL_LIM  = 5'(COLS);
    localparam int            TW       = $clog2(COLLECT_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(COLLECT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK,
        S_WRITE,
        S_FAIL
    } state_t;

    state_t           state_reg, state_next;
    logic [3:0][4:0]  slot_i_reg, slot_i_next;
    logic [3:0][4:0]  slot_j_reg, slot_j_next;
    logic [2:0]       type_reg, type_next;
    logic [2:0]       cap_cnt_reg, cap_cnt_next;
    logic [TW-1:0]    tmo_cnt_reg, tmo_cnt_next;
    logic [2:0]       seq_cnt_reg, seq_cnt_next;
    logic             collide_reg, collide_next;
    logic             gen_enable_reg, gen_enable_next;
    logic             place_done_reg, place_done_next;
    logic             place_err_reg, place_err_next;
    logic             game_over_reg, game_over_next;
    logic [19:0]      cell_i_reg, cell_i_next;
    logic [19:0]      cell_j_reg, cell_j_next;
    logic [2:0]       active_type_reg, active_type_next;

    logic [3:0]       slot_ok;
    logic [1:0]       rd_slot, cmp_slot, wr_slot;

    // A slot is usable on the board only if both coordinates are in range.
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot_ok
        assign slot_ok[gi] = (slot_i_reg[gi] < ROW_LIM) && (slot_j_reg[gi] < COL_LIM);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= S_IDLE;
            slot_i_reg      <= '0;
            slot_j_reg      <= '0;
            type_reg        <= `NULL_PIECE;
            cap_cnt_reg     <= '0;
            tmo_cnt_reg     <= '0;
            seq_cnt_reg     <= '0;
            collide_reg     <= 1'b0;
            gen_enable_reg  <= 1'b0;
            place_done_reg  <= 1'b0;
            place_err_reg   <= 1'b0;
            game_over_reg   <= 1'b0;
            cell_i_reg      <= '0;
            cell_j_reg      <= '0;
            active_type_reg <= `NULL_PIECE;
        end else begin
            state_reg       <= state_next;
            slot_i_reg      <= slot_i_next;
            slot_j_reg      <= slot_j_next;
            type_reg        <= type_next;
            cap_cnt_reg     <= cap_cnt_next;
            tmo_cnt_reg     <= tmo_cnt_next;
            seq_cnt_reg     <= seq_cnt_next;
            collide_reg     <= collide_next;
            gen_enable_reg  <= gen_enable_next;
            place_done_reg  <= place_done_next;
            place_err_reg   <= place_err_next;
            game_over_reg   <= game_over_next;
            cell_i_reg      <= cell_i_next;
            cell_j_reg      <= cell_j_next;
            active_type_reg <= active_type_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        slot_i_next      = slot_i_reg;
        slot_j_next      = slot_j_reg;
        type_next        = type_reg;
        cap_cnt_next     = cap_cnt_reg;
        tmo_cnt_next     = tmo_cnt_reg;
        seq_cnt_next     = seq_cnt_reg;
        collide_next     = collide_reg;
        gen_enable_next  = gen_enable_reg;
        place_done_next  = 1'b0;
        place_err_next   = 1'b0;
        game_over_next   = game_over_reg;
        cell_i_next      = cell_i_reg;
        cell_j_next      = cell_j_reg;
        active_type_next = active_type_reg;
        board_rd_i       = '0;
        board_rd_j       = '0;
        board_we         = 1'b0;
        board_wr_i       = '0;
        board_wr_j       = '0;
        board_wr_data    = `NULL_PIECE;
        rd_slot          = seq_cnt_reg[1:0];
        cmp_slot         = seq_cnt_reg[1:0] - 2'd1;
        wr_slot          = seq_cnt_reg[1:0];

        case (state_reg)
            S_IDLE: begin
                if (start && !game_over_reg) begin
                    state_next      = S_COLLECT;
                    gen_enable_next = 1'b1;
                    cap_cnt_next    = '0;
                    tmo_cnt_next    = '0;
                    collide_next    = 1'b0;
                end
            end

            S_COLLECT: begin
                if (gen_done && cap_cnt_reg == 3'd4) begin
                    gen_enable_next = 1'b0;
                    seq_cnt_next    = '0;
                    state_next      = S_CHECK;
                end else begin
                    // A stalled generator may keep streaming; extra cells are dropped.
                    if (!gen_done && cap_cnt_reg != 3'd4) begin
                        slot_i_next[cap_cnt_reg[1:0]] = gen_pos_i;
                        slot_j_next[cap_cnt_reg[1:0]] = gen_pos_j;
                        if (cap_cnt_reg == 3'd0) begin
                            type_next = gen_piece_type;
                        end
                        cap_cnt_next = cap_cnt_reg + 3'd1;
                    end
                    if (tmo_cnt_reg == TMO_LAST) begin
                        gen_enable_next = 1'b0;
                        place_done_next = 1'b1;
                        place_err_next  = 1'b1;
                        state_next      = S_IDLE;
                    end else begin
                        tmo_cnt_next = tmo_cnt_reg + 1'b1;
                    end
                end
            end

            // Read slot n in CHECK cycle n, judge it in cycle n+1 when the
            // board data arrives; cycle 4 only judges slot 3.
            S_CHECK: begin
                if (seq_cnt_reg != 3'd4 && slot_ok[rd_slot]) begin
                    board_rd_i = slot_i_reg[rd_slot];
                    board_rd_j = slot_j_reg[rd_slot];
                end
                if (seq_cnt_reg != 3'd0) begin
                    if (!slot_ok[cmp_slot] || board_rd_data != `NULL_PIECE) begin
                        collide_next = 1'b1;
                    end
                end
                if (seq_cnt_reg == 3'd4) begin
                    seq_cnt_next = '0;
`ifdef SPAWN_OVERWRITE_EN
                    state_next   = S_WRITE;
`else
                    state_next   = collide_next ? S_FAIL : S_WRITE;
`endif
                end else begin
                    seq_cnt_next = seq_cnt_reg + 3'd1;
                end
            end

            S_WRITE: begin
                board_wr_data = type_reg;
                if (slot_ok[wr_slot]) begin
                    board_we   = 1'b1;
                    board_wr_i = slot_i_reg[wr_slot];
                    board_wr_j = slot_j_reg[wr_slot];
                end
                if (seq_cnt_reg == 3'd3) begin
                    seq_cnt_next = '0;
                    // Only reachable with collide set when overwrite is enabled.
                    if (collide_reg) begin
                        state_next = S_FAIL;
                    end else begin
                        cell_i_next      = slot_i_reg;
                        cell_j_next      = slot_j_reg;
                        active_type_next = type_reg;
                        place_done_next  = 1'b1;
                        state_next       = S_IDLE;
                    end
                end else begin
                    seq_cnt_next = seq_cnt_reg + 3'd1;
                end
            end

            S_FAIL: begin
                game_over_next  = 1'b1;
                place_done_next = 1'b1;
                state_next      = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign gen_enable        = gen_enable_reg;
    assign gen_real_generate = gen_enable_reg;
    assign cell_i            = cell_i_reg;
    assign cell_j            = cell_j_reg;
    assign active_type       = active_type_reg;
    assign busy              = (state_reg != S_IDLE);
    assign place_done        = place_done_reg;
    assign place_err         = place_err_reg;
    assign game_over         = game_over_reg;

endmodule
